// File: rtl/loop_addr_gen_pkg.sv
// loop_addr_gen_pkg: shared types and limits for the nested-loop address generator.
package loop_addr_gen_pkg;
    typedef enum logic [0:0] {IDLE, RUN} agen_state_e;
    localparam int MAX_LOOPS = 4;
endpackage

// File: rtl/loop_addr_gen_level.sv
// loop_level_ctr: one nested-loop level holding its index, bound, stride and running base address.
module loop_level_ctr #(
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter bit HOLD_BASE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [CNT_WIDTH-1:0]  cfg_bound,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic                  step,
    input  logic                  descend,
    input  logic [ADDR_WIDTH-1:0] refill,
    output logic [CNT_WIDTH-1:0]  idx,
    output logic                  at_bound,
    output logic [ADDR_WIDTH-1:0] next_base,
    output logic [ADDR_WIDTH-1:0] stride
);
    logic [CNT_WIDTH-1:0]  bound;
    logic [ADDR_WIDTH-1:0] lvl_base;

    assign at_bound  = idx == bound;
    assign next_base = lvl_base + stride;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            bound    <= '0;
            lvl_base <= '0;
            stride   <= '0;
        end else if (load) begin
            idx      <= '0;
            bound    <= cfg_bound;
            lvl_base <= cfg_base;
            stride   <= cfg_stride;
        end else if (step) begin
            idx      <= at_bound ? '0 : idx + 1'b1;
            lvl_base <= descend ? refill : (HOLD_BASE ? lvl_base : next_base);
        end
    end
endmodule

// File: rtl/loop_addr_gen.sv
// loop_addr_gen: nested-loop address generator with valid/ready output and one-cycle done pulse.
module loop_addr_gen
    import loop_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int NUM_LOOPS  = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [ADDR_WIDTH-1:0]           base_i,
    input  logic [NUM_LOOPS*CNT_WIDTH-1:0]  bound_i,
    input  logic [NUM_LOOPS*ADDR_WIDTH-1:0] stride_i,
    input  logic                            abort_i,
    output logic                            addr_valid_o,
    input  logic                            addr_ready_i,
    output logic [ADDR_WIDTH-1:0]           addr_o,
    output logic [NUM_LOOPS*CNT_WIDTH-1:0]  idx_o,
    output logic                            last_o,
    output logic                            busy_o,
    output logic                            done_o
);
    agen_state_e           state, next_state;
    logic [NUM_LOOPS:0]    carry;
    logic [NUM_LOOPS-1:0]  at_bound;
    logic [ADDR_WIDTH-1:0] next_base [NUM_LOOPS];
    logic [ADDR_WIDTH-1:0] stride    [NUM_LOOPS];
    logic [ADDR_WIDTH-1:0] stop_base;
    logic                  load, xfer, done_q;

    assign load     = cfg_valid_i && cfg_ready_o;
    assign xfer     = addr_valid_o && addr_ready_i;
    assign carry[0] = xfer;

    for (genvar g = 0; g < NUM_LOOPS; g++) begin : g_lvl
        // Carry reaches level g+1 only when every level at or below g sits at its bound.
        assign carry[g+1] = xfer && &at_bound[g:0];
        loop_level_ctr #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .CNT_WIDTH (CNT_WIDTH),
            .HOLD_BASE (g == 0)
        ) u_lvl (
            .clk       (clk_i),
            .rst       (rst_i),
            .load      (load),
            .cfg_bound (bound_i[g*CNT_WIDTH +: CNT_WIDTH]),
            .cfg_base  (base_i),
            .cfg_stride(stride_i[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .step      (carry[g]),
            .descend   (carry[g+1]),
            .refill    (stop_base),
            .idx       (idx_o[g*CNT_WIDTH +: CNT_WIDTH]),
            .at_bound  (at_bound[g]),
            .next_base (next_base[g]),
            .stride    (stride[g])
        );
    end

    // New base of the level where the carry stops; lower levels restart from it.
    always_comb begin
        stop_base = '0;
        for (int k = 1; k < NUM_LOOPS; k++)
            stop_base = (carry[k] && !carry[k+1]) ? next_base[k] : stop_base;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = (state == IDLE) ? (cfg_valid_i ? RUN : IDLE)
                   : ((abort_i || (xfer && last_o)) ? IDLE : RUN);
    end

    always_comb begin
        cfg_ready_o  = state == IDLE;
        busy_o       = state == RUN;
        addr_valid_o = busy_o;
        last_o       = busy_o && &at_bound;
        done_o       = done_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_o <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && last_o;
            if (load)
                addr_o <= base_i;
            else if (xfer && !last_o)
                addr_o <= carry[1] ? stop_base : addr_o + stride[0];
        end
    end
endmodule

// File: tb/tb_loop_addr_gen.sv
// tb_loop_addr_gen: directed self-checking bench for loop_addr_gen (3 levels, 16-bit addresses).
module tb_loop_addr_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] base = '0;
    logic [23:0] bound = '0;
    logic [47:0] stride = '0;
    logic        abort = 1'b0;
    logic        addr_valid;
    logic        addr_ready = 1'b0;
    logic [15:0] addr;
    logic [23:0] idx;
    logic        last, busy, done;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] last_seen;

    loop_addr_gen dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .base_i      (base),
        .bound_i     (bound),
        .stride_i    (stride),
        .abort_i     (abort),
        .addr_valid_o(addr_valid),
        .addr_ready_i(addr_ready),
        .addr_o      (addr),
        .idx_o       (idx),
        .last_o      (last),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [15:0] b, input logic [23:0] bd, input logic [47:0] st);
        chk("cfg_ready_idle", cfg_ready, 1);
        base = b; bound = bd; stride = st; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Streams one run; expected address of transfer t is base + sum(i_k*stride_k).
    task automatic stream(input logic [15:0] b, input logic [23:0] bd, input logic [47:0] st,
                          input bit rnd, input int abort_after, input bit b2b, input logic [15:0] nb);
        int n = 1, cnt = 0, cyc = 0, rem;
        bit stalled = 0, r;
        logic [15:0] p_addr, e_addr;
        logic [23:0] p_idx, e_idx;
        logic        p_last;
        for (int k = 0; k < 3; k++) n *= int'(bd[k*8 +: 8]) + 1;
        while (cnt < n && cyc < 1000) begin
            chk("addr_valid", addr_valid, 1);
            if (stalled) begin
                chk("stall_addr", addr, p_addr);
                chk("stall_idx", idx, p_idx);
                chk("stall_last", last, p_last);
            end
            if (cnt == abort_after) begin
                addr_ready = 1'b0; abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_valid", addr_valid, 0);
                chk("abort_ready", cfg_ready, 1);
                chk("abort_done", done, 0);
                @(negedge clk);
                chk("abort_done2", done, 0);
                return;
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r) begin
                rem = cnt; e_addr = b; e_idx = '0;
                for (int k = 0; k < 3; k++) begin
                    e_idx[k*8 +: 8] = 8'(rem % (int'(bd[k*8 +: 8]) + 1));
                    rem = rem / (int'(bd[k*8 +: 8]) + 1);
                    e_addr = e_addr + 16'(e_idx[k*8 +: 8] * st[k*16 +: 16]);
                end
                chk("addr", addr, e_addr);
                chk("idx", idx, e_idx);
                chk("last", last, cnt == n - 1);
                last_seen = addr;
            end
            p_addr = addr; p_idx = idx; p_last = last;
            stalled = !r; addr_ready = r; cnt += int'(r); cyc++;
            @(negedge clk);
        end
        addr_ready = 1'b0;
        chk("transfer_count", cnt, n);
        chk("done_pulse", done, 1);
        chk("end_valid", addr_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_cfg_ready", cfg_ready, 1);
        if (b2b) begin
            base = nb; cfg_valid = 1'b1;
            @(negedge clk);
            cfg_valid = 1'b0;
            return;
        end
        @(negedge clk);
        chk("done_once", done, 0);
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_valid", addr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", last, 0);
        chk("rst_addr", addr, 0);
        chk("rst_idx", idx, 0);
        rst = 1'b0;
        @(negedge clk);
        // 1: full 24-address run, ready always high
        start(16'h0100, {8'd1, 8'd2, 8'd3}, {16'h40, 16'h10, 16'h1});
        stream(16'h0100, {8'd1, 8'd2, 8'd3}, {16'h40, 16'h10, 16'h1}, 0, -1, 0, 0);
        chk("t1_final_addr", last_seen, 16'h0163);
        // 2: same run with random backpressure
        start(16'h0100, {8'd1, 8'd2, 8'd3}, {16'h40, 16'h10, 16'h1});
        stream(16'h0100, {8'd1, 8'd2, 8'd3}, {16'h40, 16'h10, 16'h1}, 1, -1, 0, 0);
        chk("t2_final_addr", last_seen, 16'h0163);
        // 3: all bounds zero
        start(16'hABCD, 24'h0, {16'h7, 16'h5, 16'h3});
        stream(16'hABCD, 24'h0, {16'h7, 16'h5, 16'h3}, 0, -1, 0, 0);
        chk("t3_addr", last_seen, 16'hABCD);
        // 4: address wraps modulo 2^16
        start(16'hFFF0, {8'd0, 8'd0, 8'd3}, {16'h0, 16'h0, 16'h8});
        stream(16'hFFF0, {8'd0, 8'd0, 8'd3}, {16'h0, 16'h0, 16'h8}, 0, -1, 0, 0);
        chk("t4_final_addr", last_seen, 16'h0008);
        // 5: abort after five transfers, then a clean run
        start(16'h0100, {8'd1, 8'd2, 8'd3}, {16'h40, 16'h10, 16'h1});
        stream(16'h0100, {8'd1, 8'd2, 8'd3}, {16'h40, 16'h10, 16'h1}, 0, 5, 0, 0);
        chk("t5_abort_last", last_seen, 16'h0110);
        start(16'h0200, {8'd0, 8'd0, 8'd2}, {16'h0, 16'h0, 16'h4});
        stream(16'h0200, {8'd0, 8'd0, 8'd2}, {16'h0, 16'h0, 16'h4}, 0, -1, 0, 0);
        chk("t5_final_addr", last_seen, 16'h0208);
        // 6: asynchronous reset mid-run under backpressure
        start(16'h0500, {8'd1, 8'd1, 8'd1}, {16'h100, 16'h10, 16'h1});
        addr_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t6_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", addr_valid, 0);
        chk("t6_rst_addr", addr, 0);
        chk("t6_rst_idx", idx, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_last", last, 0);
        chk("t6_rst_ready", cfg_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_idle_ready", cfg_ready, 1);
        chk("t6_idle_done", done, 0);
        // back-to-back config accepted during done
        start(16'h0300, {8'd0, 8'd1, 8'd1}, {16'h0, 16'h20, 16'h2});
        stream(16'h0300, {8'd0, 8'd1, 8'd1}, {16'h0, 16'h20, 16'h2}, 0, -1, 1, 16'h0400);
        chk("b2b_first_addr", addr, 16'h0400);
        stream(16'h0400, {8'd0, 8'd1, 8'd1}, {16'h0, 16'h20, 16'h2}, 0, -1, 0, 0);
        chk("b2b_final_addr", last_seen, 16'h0422);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
